// File: rtl/psone_debounce_bank.sv
// psone_debounce_bank
// Multi-channel key debouncer for the PS-one pad front end. Each raw key line
// goes through a two-flop synchroniser and then a stability counter that is
// advanced by the shared iTICK strobe. oKEY follows a line only after it has
// been quiet for 2^(CNT_W-1) counted ticks.
//
// Build option: define PSONE_DEBOUNCE_EVT_EN to generate the oPRESS, oRELEASE
// and oCHANGE event outputs. Without it those outputs are tied to 0, and
// oKEY behaves and is timed exactly the same.

module psone_debounce_bank #(
  parameter int                  CHANNELS   = 16,
  parameter int                  CNT_W      = 11,
  parameter logic [CHANNELS-1:0] INIT       = {CHANNELS{1'b1}},
  parameter bit                  ACTIVE_LOW = 1'b1
) (
  input  logic                iCLK,
  input  logic                iRESET,
  input  logic                iTICK,
  input  logic [CHANNELS-1:0] iKEY,
  output logic [CHANNELS-1:0] oKEY,
  output logic [CHANNELS-1:0] oPRESS,
  output logic [CHANNELS-1:0] oRELEASE,
  output logic                oCHANGE
);

  logic [CHANNELS-1:0] s1;
  logic [CHANNELS-1:0] s2;
  logic [CHANNELS-1:0] edge_det;
  logic [CHANNELS-1:0] stable;
  logic [CHANNELS-1:0] key_next;
  logic [CHANNELS-1:0] pressed_now;
  logic [CHANNELS-1:0] pressed_next;
  logic [CHANNELS-1:0] press_next;
  logic [CHANNELS-1:0] release_next;
  logic [CNT_W-1:0]    cnt [CHANNELS];

  // Two-stage synchroniser for the asynchronous pad lines
  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      s1 <= INIT;
      s2 <= INIT;
    end else begin
      s1 <= iKEY;
      s2 <= s1;
    end
  end

  assign edge_det = s1 ^ s2;

  // Per-channel stability counters: an edge restarts, a tick advances until MSB saturates
  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      for (int i = 0; i < CHANNELS; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (edge_det[i]) begin
          cnt[i] <= '0;
        end else if (!cnt[i][CNT_W-1] && iTICK) begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // A channel is STABLE once its counter MSB is set; COUNTING otherwise
  always_comb begin
    stable = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      stable[i] = cnt[i][CNT_W-1];
    end
  end

  assign key_next = (stable & s2) | (~stable & oKEY);

  // Debounced level register, copies the synchronised line only while stable
  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      oKEY <= INIT;
    end else begin
      oKEY <= key_next;
    end
  end

  // Pressed-level view of the current and next debounced vectors
  assign pressed_now  = ACTIVE_LOW ? ~oKEY     : oKEY;
  assign pressed_next = ACTIVE_LOW ? ~key_next : key_next;
  assign press_next   = pressed_next & ~pressed_now;
  assign release_next = ~pressed_next & pressed_now;

`ifdef PSONE_DEBOUNCE_EVT_EN
  // Event pulses land on the same edge as the oKEY update they describe
  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      oPRESS   <= '0;
      oRELEASE <= '0;
      oCHANGE  <= 1'b0;
    end else begin
      oPRESS   <= press_next;
      oRELEASE <= release_next;
      oCHANGE  <= |(press_next | release_next);
    end
  end
`else
  // Events compiled out; the edge decode is left unconnected
  logic unused_evt;
  assign unused_evt = ^{press_next, release_next};
  assign oPRESS     = '0;
  assign oRELEASE   = '0;
  assign oCHANGE    = 1'b0;
`endif

endmodule

// File: tb/tb_psone_debounce_bank.sv
// tb_psone_debounce_bank
// Directed bench for psone_debounce_bank with CHANNELS=16, CNT_W=4, so a
// change reaches oKEY 11 edges after iKEY moves when iTICK is held high.
// Event expectations collapse to 0 when PSONE_DEBOUNCE_EVT_EN is undefined.

module tb_psone_debounce_bank;

  localparam int CH = 16;

`ifdef PSONE_DEBOUNCE_EVT_EN
  localparam bit EVT = 1'b1;
`else
  localparam bit EVT = 1'b0;
`endif

  logic          iCLK = 1'b0;
  logic          iRESET;
  logic          iTICK;
  logic [CH-1:0] iKEY;
  logic [CH-1:0] oKEY;
  logic [CH-1:0] oPRESS;
  logic [CH-1:0] oRELEASE;
  logic          oCHANGE;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic          rst;
    logic          tick;
    logic [CH-1:0] key;
    logic [CH-1:0] e_key;
    logic [CH-1:0] e_press;
    logic [CH-1:0] e_rel;
    logic          e_chg;
  } vec_t;

  vec_t vecs[$];

  psone_debounce_bank #(
    .CHANNELS  (CH),
    .CNT_W     (4),
    .INIT      (16'hFFFF),
    .ACTIVE_LOW(1'b1)
  ) dut (
    .iCLK    (iCLK),
    .iRESET  (iRESET),
    .iTICK   (iTICK),
    .iKEY    (iKEY),
    .oKEY    (oKEY),
    .oPRESS  (oPRESS),
    .oRELEASE(oRELEASE),
    .oCHANGE (oCHANGE)
  );

  // Free-running 10 ns clock
  always #5 iCLK = ~iCLK;

  // Drive inputs, take one rising edge, then settle 1 ns before sampling
  task automatic applyStimulus(input logic rst, input logic tick, input logic [CH-1:0] key);
    iRESET = rst;
    iTICK  = tick;
    iKEY   = key;
    @(posedge iCLK);
    #1;
  endtask

  // Compare every output; event expectations are masked when events are compiled out
  task automatic checkOutput(input string name, input logic [CH-1:0] ek,
                             input logic [CH-1:0] ep, input logic [CH-1:0] er,
                             input logic ec);
    logic [CH-1:0] wp;
    logic [CH-1:0] wr;
    logic          wc;
    wp = EVT ? ep : '0;
    wr = EVT ? er : '0;
    wc = EVT ? ec : 1'b0;
    checks += 4;
    if (oKEY !== ek) begin
      errors++;
      $display("[TB] FAIL %s oKEY got %h want %h", name, oKEY, ek);
    end
    if (oPRESS !== wp) begin
      errors++;
      $display("[TB] FAIL %s oPRESS got %h want %h", name, oPRESS, wp);
    end
    if (oRELEASE !== wr) begin
      errors++;
      $display("[TB] FAIL %s oRELEASE got %h want %h", name, oRELEASE, wr);
    end
    if (oCHANGE !== wc) begin
      errors++;
      $display("[TB] FAIL %s oCHANGE got %b want %b", name, oCHANGE, wc);
    end
  endtask

  task automatic addVec(input logic rst, input logic tick, input logic [CH-1:0] key,
                        input logic [CH-1:0] ek, input logic [CH-1:0] ep,
                        input logic [CH-1:0] er, input logic ec);
    vec_t v;
    v.rst = rst; v.tick = tick; v.key = key;
    v.e_key = ek; v.e_press = ep; v.e_rel = er; v.e_chg = ec;
    vecs.push_back(v);
  endtask

  // Idle with all keys released until every channel is stable again
  task automatic settle(input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b0, 1'b1, 16'hFFFF);
    end
  endtask

  initial begin
    iRESET = 1'b1;
    iTICK  = 1'b1;
    iKEY   = 16'hFFFF;

    // Table: reset, settle, press key 3, release key 3
    addVec(1'b1, 1'b1, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000, 1'b0);
    for (int i = 0; i < 11; i++)
      addVec(1'b0, 1'b1, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000, 1'b0);
    for (int i = 1; i <= 10; i++)
      addVec(1'b0, 1'b1, 16'hFFF7, 16'hFFFF, 16'h0000, 16'h0000, 1'b0);
    addVec(1'b0, 1'b1, 16'hFFF7, 16'hFFF7, 16'h0008, 16'h0000, 1'b1);
    addVec(1'b0, 1'b1, 16'hFFF7, 16'hFFF7, 16'h0000, 16'h0000, 1'b0);
    for (int i = 1; i <= 10; i++)
      addVec(1'b0, 1'b1, 16'hFFFF, 16'hFFF7, 16'h0000, 16'h0000, 1'b0);
    addVec(1'b0, 1'b1, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h0008, 1'b1);
    addVec(1'b0, 1'b1, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000, 1'b0);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].rst, vecs[i].tick, vecs[i].key);
      checkOutput($sformatf("vec%0d", i), vecs[i].e_key, vecs[i].e_press,
                  vecs[i].e_rel, vecs[i].e_chg);
    end

    // Glitch on key 0 shorter than the threshold never reaches oKEY
    for (int j = 1; j <= 7; j++) begin
      applyStimulus(1'b0, 1'b1, 16'hFFFE);
      checkOutput("glitch_low", 16'hFFFF, 16'h0000, 16'h0000, 1'b0);
    end
    for (int j = 1; j <= 14; j++) begin
      applyStimulus(1'b0, 1'b1, 16'hFFFF);
      checkOutput("glitch_high", 16'hFFFF, 16'h0000, 16'h0000, 1'b0);
    end

    // Keys 1 and 9 pressed together, then released together
    for (int j = 1; j <= 12; j++) begin
      applyStimulus(1'b0, 1'b1, 16'hFDFD);
      if (j < 11)       checkOutput("dual_press_wait", 16'hFFFF, 16'h0000, 16'h0000, 1'b0);
      else if (j == 11) checkOutput("dual_press",      16'hFDFD, 16'h0202, 16'h0000, 1'b1);
      else              checkOutput("dual_press_end",  16'hFDFD, 16'h0000, 16'h0000, 1'b0);
    end
    for (int j = 1; j <= 12; j++) begin
      applyStimulus(1'b0, 1'b1, 16'hFFFF);
      if (j < 11)       checkOutput("dual_rel_wait", 16'hFDFD, 16'h0000, 16'h0000, 1'b0);
      else if (j == 11) checkOutput("dual_rel",      16'hFFFF, 16'h0000, 16'h0202, 1'b1);
      else              checkOutput("dual_rel_end",  16'hFFFF, 16'h0000, 16'h0000, 1'b0);
    end

    // Tick one cycle in four: 8 ticks on edges 4..32, oKEY[5] falls on edge 33
    for (int j = 1; j <= 36; j++) begin
      applyStimulus(1'b0, (j % 4) == 0, 16'hFFDF);
      if (j < 33)       checkOutput("slow_tick_wait", 16'hFFFF, 16'h0000, 16'h0000, 1'b0);
      else if (j == 33) checkOutput("slow_tick",      16'hFFDF, 16'h0020, 16'h0000, 1'b1);
      else              checkOutput("slow_tick_end",  16'hFFDF, 16'h0000, 16'h0000, 1'b0);
    end
    for (int j = 1; j <= 12; j++) begin
      applyStimulus(1'b0, 1'b1, 16'hFFFF);
      if (j == 11) checkOutput("slow_tick_rel", 16'hFFFF, 16'h0000, 16'h0020, 1'b1);
    end

    // Reset mid-count on key 2, then a full 11-edge delay from scratch
    for (int j = 1; j <= 7; j++) begin
      applyStimulus(1'b0, 1'b1, 16'hFFFB);
    end
    checkOutput("midcount_pre", 16'hFFFF, 16'h0000, 16'h0000, 1'b0);
    applyStimulus(1'b1, 1'b1, 16'hFFFB);
    checkOutput("midcount_reset", 16'hFFFF, 16'h0000, 16'h0000, 1'b0);
    for (int j = 1; j <= 12; j++) begin
      applyStimulus(1'b0, 1'b1, 16'hFFFB);
      if (j < 11)       checkOutput("post_reset_wait", 16'hFFFF, 16'h0000, 16'h0000, 1'b0);
      else if (j == 11) checkOutput("post_reset",      16'hFFFB, 16'h0004, 16'h0000, 1'b1);
      else              checkOutput("post_reset_end",  16'hFFFB, 16'h0000, 16'h0000, 1'b0);
    end

    // Reset while a key is debounced-pressed returns oKEY to INIT with no event
    applyStimulus(1'b1, 1'b1, 16'hFFFB);
    checkOutput("reset_pressed", 16'hFFFF, 16'h0000, 16'h0000, 1'b0);
    settle(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
